gs_iter_ctrl: RTL and testbench
===============================

Name: gs_iter_ctrl

Overview:
Sequential controller for the combinational single-step Goldschmidt divider stage on the 8-bit mini-float format. It accepts a dividend/divisor pair over a valid/ready handshake, screens special cases, and seeds the reciprocal estimate from an exponent ROM. It then drives the divider stage once per clock, feeding each new xi back into the stage, until convergence or the iteration limit. It returns the quotient over a second valid/ready handshake.

Parameters:
MAX_ITER, 3, maximum Goldschmidt steps per division (1..7).
ITER_W, 3, width of the iteration counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  operand pair valid.
in_ready  out  1  controller can accept operands.
in_a  in  8  dividend, mini-float.
in_b  in  8  divisor, mini-float.
stage_a  out  8  dividend to divider stage.
stage_b  out  8  divisor to divider stage.
stage_xi  out  8  current multiplier xi to divider stage.
stage_c  in  8  stage output: scaled divisor Di.
stage_d  in  8  stage output: scaled dividend Ni (quotient candidate).
stage_xinew  in  8  stage output: next xi.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
q  out  8  quotient, mini-float.
dbz  out  1  divide by zero.
err  out  1  divisor exponent outside seed table.
iters  out  ITER_W  steps used for this result.

Behaviour:
- Format: [7] sign, [6:3] exponent with bias 7, [2:0] fraction with hidden 1. 8'h00 is zero.
- Reset (async): state IDLE. out_valid, q, dbz, err, iters, stage_a, stage_b and stage_xi are all 0. in_ready is 1 (in_ready is 1 exactly when state is IDLE).
- States: IDLE, ITER, DONE.
- IDLE: on an edge with in_valid&in_ready, register in_a/in_b into stage_a/stage_b.
  - If in_b==0: DONE, q={in_a[7]^in_b[7],7'h7F}, dbz=1, iters=0.
  - Else if in_a==0: DONE, q=8'h00, iters=0.
  - Else if seed(in_b[6:3])==0: DONE, q=8'h00, err=1.
  - Else: ITER, stage_xi={1'b0,seed,3'b000}, iter counter=1.
  - dbz takes priority over the zero-dividend case.
- Seed table (divisor exponent->xi exponent): 4->10, 5->9, 6->8, 7->7, 8->6, 9->5, 10->4. All other exponents give 0, which is the err case.
- ITER: the stage is combinational from stage_a/stage_b/stage_xi. On each edge:
  - q<=stage_d and iters<=counter.
  - Converged means stage_c is one of 8'h38, 8'h37, 8'h36, 8'h34, or stage_xinew==8'h00.
  - If converged or counter==MAX_ITER: go to DONE.
  - Otherwise: stage_xi<=stage_xinew and counter++.
- Latency: out_valid rises k edges after the accept edge, where k is the number of steps used (1..MAX_ITER). Special cases take 1 edge.
- DONE: out_valid=1 and q/dbz/err/iters are held stable until out_ready. On the edge with out_ready: out_valid<=0, dbz<=0, err<=0, go to IDLE.
  - This gives one bubble cycle between results.
  - q keeps its last value after the handshake.
- in_valid while not in IDLE is ignored (in_ready=0). in_a/in_b are sampled only on the accept edge.
- rst asserted mid-ITER or mid-DONE aborts immediately to reset values. No result is produced for the aborted operation.
- Counter never wraps: MAX_ITER < 2^ITER_W is enforced by an elaboration check.

Optional Feature:
GS_EARLY_EXIT_EN
- Defined: convergence test active as described above.
- Undefined: convergence test removed; ITER always runs exactly MAX_ITER steps, and iters always reports MAX_ITER for non-special results.

Decomposition:
- Package gs_pkg holds:
  - field slices (SIGN_BIT, EXP_MSB/LSB, FRAC_MSB/LSB) and EXP_BIAS=7;
  - MF_ZERO=8'h00 and MF_MAXMAG=7'h7F;
  - the converged-code constants 8'h38, 8'h37, 8'h36, 8'h34;
  - the state enum {IDLE, ITER, DONE}.
- One sub-module, gs_seed_rom: combinational 4-bit exponent to 4-bit seed exponent, table above.

Test Plan:
- A=8'h38, B=8'h38, bench stage returns stage_c=8'h38, stage_d=8'h38 on step 1 -> out_valid 1 edge after accept, q=8'h38, iters=1, dbz=0, err=0.
- A=8'h40, B=8'h44, stage_c sequence 8'h33, 8'h35, 8'h30 (never converged) -> stage_xi follows stage_xinew each step, out_valid after 3 edges, iters=3, q = stage_d of step 3.
  - With GS_EARLY_EXIT_EN undefined, converged stage_c on step 1 still gives iters=3.
- A=8'hC0, B=8'h00 -> next edge out_valid, q=8'hFF, dbz=1, no ITER cycles.
- A=8'h00, B=8'h48 -> out_valid after 1 edge, q=8'h00, dbz=0.
- B=8'h60 (exponent 12) -> err=1, q=8'h00.
- Handshake:
  - out_ready held 0 for 5 cycles: q/flags stable throughout, in_ready=0.
  - After the out_ready edge: in_ready=1 next cycle.
  - rst pulsed during step 2: all outputs 0 asynchronously, in_ready=1, and a new operand pair is accepted afterwards.

Source files
------------

// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared constants and types for the Goldschmidt iteration controller
//
// Purpose: mini-float field slices, special codes, convergence codes and the
// controller state enum used by gs_iter_ctrl and gs_seed_rom.
// Ports: none (package).
package gs_pkg;

  // Mini-float layout: [7] sign, [6:3] exponent (bias 7), [2:0] fraction, hidden 1
  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 3;
  localparam int FRAC_MSB = 2;
  localparam int FRAC_LSB = 0;
  localparam int EXP_BIAS = 7;

  localparam logic [7:0] MF_ZERO   = 8'h00;
  localparam logic [6:0] MF_MAXMAG = 7'h7F;

  // Scaled-divisor codes close enough to 1.0 to stop iterating
  localparam logic [7:0] CONV_C0 = 8'h38;
  localparam logic [7:0] CONV_C1 = 8'h37;
  localparam logic [7:0] CONV_C2 = 8'h36;
  localparam logic [7:0] CONV_C3 = 8'h34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_conv_code(input logic [7:0] c);
    return (c == CONV_C0) || (c == CONV_C1) || (c == CONV_C2) || (c == CONV_C3);
  endfunction

endpackage

// File: rtl/gs_seed_rom.sv
// rtl/gs_seed_rom.sv - divisor exponent to reciprocal seed exponent lookup
//
// Purpose: combinational seed table for the first Goldschmidt multiplier.
// Ports:
//   i_exp  - divisor exponent field (4 bits)
//   o_seed - seed exponent for xi, 0 when the exponent is outside the table
module gs_seed_rom (
  input  logic [3:0] i_exp,
  output logic [3:0] o_seed
);

  always_comb begin
    o_seed = 4'd0;
    case (i_exp)
      4'd4:    o_seed = 4'd10;
      4'd5:    o_seed = 4'd9;
      4'd6:    o_seed = 4'd8;
      4'd7:    o_seed = 4'd7;
      4'd8:    o_seed = 4'd6;
      4'd9:    o_seed = 4'd5;
      4'd10:   o_seed = 4'd4;
      default: o_seed = 4'd0;
    endcase
  end

endmodule

// File: rtl/gs_iter_ctrl.sv
// rtl/gs_iter_ctrl.sv - sequential controller for the single-step Goldschmidt divider stage
//
// Purpose: accepts a mini-float dividend/divisor pair, screens zero divisor,
// zero dividend and out-of-table divisor exponents, seeds xi from gs_seed_rom,
// then steps the external combinational stage once per clock until the scaled
// divisor converges or MAX_ITER steps are used, and returns the quotient.
// Optional feature macro: GS_EARLY_EXIT_EN (defined: convergence test enabled;
// undefined: always MAX_ITER steps).
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b  - operand handshake
//   stage_a/stage_b/stage_xi     - operands driven to the divider stage
//   stage_c/stage_d/stage_xinew  - divider stage outputs Di, Ni, next xi
//   out_valid/out_ready          - result handshake
//   q, dbz, err, iters           - quotient, divide-by-zero, seed error, steps used
module gs_iter_ctrl
  import gs_pkg::*;
#(
  parameter int MAX_ITER = 3,
  parameter int ITER_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  output logic [7:0]        stage_a,
  output logic [7:0]        stage_b,
  output logic [7:0]        stage_xi,
  input  logic [7:0]        stage_c,
  input  logic [7:0]        stage_d,
  input  logic [7:0]        stage_xinew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        q,
  output logic              dbz,
  output logic              err,
  output logic [ITER_W-1:0] iters
);

  generate
    if (MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W)) begin : g_bad_cfg
      $error("gs_iter_ctrl: MAX_ITER must be in 1..2**ITER_W-1");
    end
  endgenerate

`ifdef GS_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [ITER_W-1:0] r_cnt;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [7:0]        r_xi;
  logic [7:0]        r_q;
  logic              r_dbz;
  logic              r_err;
  logic [ITER_W-1:0] r_iters;

  logic [3:0]        w_seed;
  logic              w_b_zero;
  logic              w_a_zero;
  logic              w_special;
  logic              w_conv;
  logic              w_last;
  logic              w_stop;

  gs_seed_rom u_seed_rom (
    .i_exp  (in_b[EXP_MSB:EXP_LSB]),
    .o_seed (w_seed)
  );

  assign w_b_zero  = (in_b == MF_ZERO);
  assign w_a_zero  = (in_a == MF_ZERO);
  assign w_special = w_b_zero || w_a_zero || (w_seed == 4'd0);
  // A zero next-xi means the stage has nothing left to refine
  assign w_conv    = EARLY_EXIT && (is_conv_code(stage_c) || (stage_xinew == MF_ZERO));
  assign w_last    = (r_cnt == ITER_W'(MAX_ITER));
  assign w_stop    = w_conv || w_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_special ? DONE : ITER;
      ITER:    if (w_stop) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= MF_ZERO;
      r_b     <= MF_ZERO;
      r_xi    <= MF_ZERO;
      r_q     <= MF_ZERO;
      r_dbz   <= 1'b0;
      r_err   <= 1'b0;
      r_iters <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
            // Zero divisor wins over zero dividend
            if (w_b_zero) begin
              r_q     <= {in_a[SIGN_BIT] ^ in_b[SIGN_BIT], MF_MAXMAG};
              r_dbz   <= 1'b1;
              r_iters <= '0;
            end else if (w_a_zero) begin
              r_q     <= MF_ZERO;
              r_iters <= '0;
            end else if (w_seed == 4'd0) begin
              r_q     <= MF_ZERO;
              r_err   <= 1'b1;
              r_iters <= '0;
            end else begin
              r_xi  <= {1'b0, w_seed, 3'b000};
              r_cnt <= ITER_W'(1);
            end
          end
        end
        ITER: begin
          r_q     <= stage_d;
          r_iters <= r_cnt;
          if (!w_stop) begin
            r_xi  <= stage_xinew;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_dbz <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stage_a  = r_a;
  assign stage_b  = r_b;
  assign stage_xi = r_xi;
  assign q        = r_q;
  assign dbz      = r_dbz;
  assign err      = r_err;
  assign iters    = r_iters;

endmodule

// File: tb/tb_gs_iter_ctrl.sv
// tb/tb_gs_iter_ctrl.sv - self-checking bench for gs_iter_ctrl
module tb_gs_iter_ctrl;

  localparam int MAXI = 3;
  localparam int IW   = 3;
`ifdef GS_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    in_a = 8'h00;
  logic [7:0]    in_b = 8'h00;
  logic          in_ready, out_valid, dbz, err;
  logic [7:0]    stage_a, stage_b, stage_xi, st_c, st_d, st_xn, q;
  logic [IW-1:0] iters;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gs_iter_ctrl #(.MAX_ITER(MAXI), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .stage_a(stage_a), .stage_b(stage_b), .stage_xi(stage_xi),
    .stage_c(st_c), .stage_d(st_d), .stage_xinew(st_xn),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .dbz(dbz), .err(err), .iters(iters)
  );

  // Stand-in divider stage: a per-test response table keyed on xi
  logic [7:0] t_xi[0:3], t_c[0:3], t_d[0:3], t_xn[0:3];
  int t_n = 0;

  function automatic logic [23:0] stage_ref(input logic [7:0] xi);
    logic [23:0] r;
    r = {8'h33, 8'h00, 8'h11};
    for (int i = 0; i < 4; i++)
      if (i < t_n && t_xi[i] == xi) r = {t_c[i], t_d[i], t_xn[i]};
    return r;
  endfunction

  always_comb {st_c, st_d, st_xn} = stage_ref(stage_xi);

  task automatic set_row(input int i, input logic [7:0] xi, c, d, xn);
    t_xi[i] = xi; t_c[i] = c; t_d[i] = d; t_xn[i] = xn;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Predicted outcome of the next operation, derived from the operands alone
  bit         p_special, p_dbz, p_err;
  logic [7:0] p_sq;
  int         p_k;
  logic [7:0] p_xi[0:7], p_d[0:7];

  function automatic int seed_ref(input int e);
    return (e >= 4 && e <= 10) ? 14 - e : 0;
  endfunction

  task automatic predict(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] xi, c, d, xn;
    int s;
    p_special = 1'b1; p_dbz = 1'b0; p_err = 1'b0; p_k = 0; p_sq = 8'h00;
    s = seed_ref(int'(b[6:3]));
    if (b == 8'h00) begin
      p_sq = {a[7] ^ b[7], 7'h7F}; p_dbz = 1'b1;
    end else if (a == 8'h00) begin
      p_sq = 8'h00;
    end else if (s == 0) begin
      p_sq = 8'h00; p_err = 1'b1;
    end else begin
      p_special = 1'b0;
      xi = {1'b0, 4'(s), 3'b000};
      for (int j = 1; j <= MAXI; j++) begin
        {c, d, xn} = stage_ref(xi);
        p_xi[j] = xi; p_d[j] = d; p_k = j;
        if (EARLY && (c == 8'h38 || c == 8'h37 || c == 8'h36 || c == 8'h34 || xn == 8'h00))
          break;
        xi = xn;
      end
    end
  endtask

  // Time-based tracking: edges since the accept edge decide what is visible
  logic       m_active;
  int         m_t, m_li;
  logic [7:0] m_lq, m_lx, m_a, m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_t <= 0; m_lq <= 8'h00; m_li <= 0; m_lx <= 8'h00;
      m_a <= 8'h00; m_b <= 8'h00;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1; m_t <= 0; m_a <= in_a; m_b <= in_b;
      end
    end else if (m_t < p_k) begin
      m_t <= m_t + 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
      m_lq <= p_special ? p_sq : p_d[p_k];
      m_li <= p_special ? 0 : p_k;
      if (!p_special) m_lx <= p_xi[p_k];
    end
  end

  logic       e_ready, e_valid, e_dbz, e_err;
  logic [7:0] e_q, e_xi;
  int         e_it, e_idx;

  always_comb begin
    e_ready = !m_active;
    e_valid = m_active && (m_t == p_k);
    e_q = m_lq; e_it = m_li; e_dbz = 1'b0; e_err = 1'b0; e_xi = m_lx; e_idx = 0;
    if (m_active) begin
      if (p_special) begin
        e_q = p_sq; e_it = 0; e_dbz = p_dbz; e_err = p_err;
      end else begin
        e_idx = (m_t < p_k) ? m_t + 1 : p_k;
        e_xi  = p_xi[e_idx];
        if (m_t > 0) begin
          e_q = p_d[m_t]; e_it = m_t;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("q", 32'(q), 32'(e_q));
    chk("dbz", 32'(dbz), 32'(e_dbz));
    chk("err", 32'(err), 32'(e_err));
    chk("iters", 32'(iters), 32'(e_it));
    chk("stage_xi", 32'(stage_xi), 32'(e_xi));
    chk("stage_a", 32'(stage_a), 32'(m_a));
    chk("stage_b", 32'(stage_b), 32'(m_b));
  end

  // Run one operation; returns result fields and edges after the accept edge
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       output logic [7:0] rq, output logic rdbz, output logic rerr,
                       output int rit, output int lat);
    int n;
    predict(a, b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    lat = -1;
    @(negedge clk);
    if (out_valid) lat = 0;
    in_a = 8'h55; in_b = 8'h00;   // must be ignored while busy
    @(negedge clk);
    in_valid = 1'b0;
    if (lat < 0 && out_valid) lat = 1;
    n = 1;
    while (lat < 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) lat = n;
    end
    if (lat < 0) chk("out_valid_timeout", 32'(0), 32'(1));
    repeat (hold) @(negedge clk);
    rq = q; rdbz = dbz; rerr = err; rit = int'(iters);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_ack", 32'(in_ready), 32'(1));
  endtask

  logic [7:0] rq;
  logic       rdbz, rerr;
  int         rit, lat;

  task automatic load_t1;
    t_n = 1; set_row(0, 8'h38, 8'h38, 8'h38, 8'h38);
  endtask

  task automatic load_t2;
    t_n = 3;
    set_row(0, 8'h30, 8'h33, 8'h41, 8'h31);
    set_row(1, 8'h31, 8'h35, 8'h42, 8'h32);
    set_row(2, 8'h32, 8'h30, 8'h43, 8'h33);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_q", 32'(q), 32'(0));
    chk("reset_stage_xi", 32'(stage_xi), 32'(0));
    #9 rst = 1'b0;

    load_t1;
    do_op(8'h38, 8'h38, 0, rq, rdbz, rerr, rit, lat);
    chk("t1_q", 32'(rq), 32'h38);
    chk("t1_iters", 32'(rit), EARLY ? 32'd1 : 32'd3);
    chk("t1_lat", 32'(lat), EARLY ? 32'd1 : 32'd3);
    chk("t1_flags", {30'd0, rdbz, rerr}, 32'd0);

    load_t2;
    do_op(8'h40, 8'h44, 5, rq, rdbz, rerr, rit, lat);
    chk("t2_q", 32'(rq), 32'h43);
    chk("t2_iters", 32'(rit), 32'd3);
    chk("t2_lat", 32'(lat), 32'd3);

    do_op(8'hC0, 8'h00, 5, rq, rdbz, rerr, rit, lat);
    chk("t3_q", 32'(rq), 32'hFF);
    chk("t3_dbz", 32'(rdbz), 32'd1);
    chk("t3_lat", 32'(lat), 32'd0);
    chk("t3_iters", 32'(rit), 32'd0);

    do_op(8'h00, 8'h48, 1, rq, rdbz, rerr, rit, lat);
    chk("t4_q", 32'(rq), 32'h00);
    chk("t4_flags", {30'd0, rdbz, rerr}, 32'd0);
    chk("t4_lat", 32'(lat), 32'd0);

    do_op(8'h40, 8'h60, 2, rq, rdbz, rerr, rit, lat);
    chk("t5_err", 32'(rerr), 32'd1);
    chk("t5_q", 32'(rq), 32'h00);

    do_op(8'h00, 8'h00, 0, rq, rdbz, rerr, rit, lat);
    chk("t6_q", 32'(rq), 32'h7F);
    chk("t6_dbz", 32'(rdbz), 32'd1);

    // Abort during step 2
    load_t2;
    predict(8'h40, 8'h44);
    @(negedge clk);
    in_a = 8'h40; in_b = 8'h44; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_step2_xi", 32'(stage_xi), 32'h31);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_iters", 32'(iters), 32'd0);
    chk("abort_stage", {8'd0, stage_a, stage_b, stage_xi}, 32'd0);
    chk("abort_flags", {30'd0, dbz, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    load_t1;
    do_op(8'h38, 8'h38, 0, rq, rdbz, rerr, rit, lat);
    chk("post_abort_q", 32'(rq), 32'h38);
    chk("post_abort_iters", 32'(rit), EARLY ? 32'd1 : 32'd3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
